nasti_mmio_bridge: RTL and testbench

NASTI_MMIO_BRIDGE -- requirements
Module: nasti_mmio_bridge

---
 rtl/nasti_mmio_bridge_pkg.sv | 24 ++
 rtl/nasti_mmio_bridge.sv | 242 ++++++++++++++++++++++++
 tb/tb_nasti_mmio_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nasti_mmio_bridge_pkg.sv
// Shared types and constants for the NASTI-to-MMIO register bridge.
//   state_e     : bridge FSM states
//   RESP_*      : AXI response encodings driven on b_resp / r_resp
//   DATA_W      : register data width
//   SIZE_32     : the only supported AxSIZE (4-byte beats)
package nasti_mmio_bridge_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam logic [2:0]  SIZE_32     = 3'd2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StRdData,
    StWrData,
    StWrReq,
    StWrWait,
    StWrResp
  } state_e;

endpackage

// File: rtl/nasti_mmio_bridge.sv
// NASTI (AXI3-style) slave to simple register-request bridge.
// Converts 32-bit INCR bursts from the Zynq GP master into one register request per beat,
// with a single transaction outstanding.
//
// Ports
//   clk, reset_n            : clock, asynchronous active-low reset
//   ar_* / aw_*             : read / write address channels (slave side)
//   w_*                     : write data channel
//   b_*                     : write response channel
//   r_*                     : read data channel
//   req_*                   : register request (req_addr is a word index)
//   resp_*                  : register response, always accepted
module nasti_mmio_bridge
  import nasti_mmio_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned ID_W   = 12
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [31:0]       ar_addr,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [7:0]        ar_len,
  input  logic [2:0]        ar_size,

  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [31:0]       aw_addr,
  input  logic [ID_W-1:0]   aw_id,
  input  logic [7:0]        aw_len,
  input  logic [2:0]        aw_size,

  input  logic              w_valid,
  output logic              w_ready,
  input  logic [31:0]       w_data,
  input  logic              w_last,

  output logic              b_valid,
  input  logic              b_ready,
  output logic [ID_W-1:0]   b_id,
  output logic [1:0]        b_resp,

  output logic              r_valid,
  input  logic              r_ready,
  output logic [31:0]       r_data,
  output logic [ID_W-1:0]   r_id,
  output logic              r_last,
  output logic [1:0]        r_resp,

  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_wr,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_wdata,

  input  logic              resp_valid,
  input  logic [31:0]       resp_rdata,
  input  logic              resp_err
);

  state_e              state_q, state_d;
  logic                last_wr_q, last_wr_d;   // last grant went to the write channel
  logic                granted_q, granted_d;   // any grant since reset
  logic [ID_W-1:0]     id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          beat_q, beat_d;
  logic                err_q, err_d;           // read: this beat; write: sticky
  logic                size_err_q, size_err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic ar_grant, aw_grant;
  logic pick_wr, size_bad, final_beat;

  // Address bits outside the word index are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ar_addr[31:ADDR_W+2], ar_addr[1:0],
                              aw_addr[31:ADDR_W+2], aw_addr[1:0]};

  assign final_beat = (beat_q == len_q);

  always_comb begin
    state_d    = state_q;
    last_wr_d  = last_wr_q;
    granted_d  = granted_q;
    id_d       = id_q;
    len_d      = len_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    err_d      = err_q;
    size_err_d = size_err_q;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    ar_grant   = 1'b0;
    aw_grant   = 1'b0;
    pick_wr    = 1'b0;
    size_bad   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On a tie, alternate; the very first tie after reset goes to read.
        if (ar_valid && aw_valid) pick_wr = granted_q && !last_wr_q;
        else                      pick_wr = aw_valid;
        if (ar_valid || aw_valid) begin
          ar_grant   = !pick_wr;
          aw_grant   = pick_wr;
          size_bad   = pick_wr ? (aw_size != SIZE_32) : (ar_size != SIZE_32);
          last_wr_d  = pick_wr;
          granted_d  = 1'b1;
          id_d       = pick_wr ? aw_id : ar_id;
          len_d      = pick_wr ? aw_len : ar_len;
          addr_d     = pick_wr ? aw_addr[ADDR_W+1:2] : ar_addr[ADDR_W+1:2];
          beat_d     = 8'd0;
          err_d      = size_bad;
          size_err_d = size_bad;
          rdata_d    = '0;
          if (pick_wr)       state_d = StWrData;
          else if (size_bad) state_d = StRdData;
          else               state_d = StRdReq;
        end
      end

      StRdReq: begin
        if (req_ready) state_d = StRdWait;
      end

      StRdWait: begin
        if (resp_valid) begin
          rdata_d = resp_rdata;
          err_d   = resp_err;
          state_d = StRdData;
        end
      end

      StRdData: begin
        if (r_ready) begin
          if (final_beat) begin
            state_d = StIdle;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_q + ADDR_W'(1);
            // Unsupported size: keep producing zero/SLVERR beats without touching registers.
            state_d = size_err_q ? StRdData : StRdReq;
          end
        end
      end

      StWrData: begin
        if (w_valid) begin
          wdata_d = w_data;
          // aw_len governs the burst; any disagreement from w_last is flagged only.
          if (w_last != final_beat) err_d = 1'b1;
          if (!size_err_q) begin
            state_d = StWrReq;
          end else if (final_beat) begin
            state_d = StWrResp;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      StWrReq: begin
        if (req_ready) state_d = StWrWait;
      end

      StWrWait: begin
        if (resp_valid) begin
          if (resp_err) err_d = 1'b1;
          if (final_beat) begin
            state_d = StWrResp;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StWrData;
          end
        end
      end

      StWrResp: begin
        if (b_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      last_wr_q  <= 1'b0;
      granted_q  <= 1'b0;
      id_q       <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      size_err_q <= 1'b0;
      rdata_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_wr_q  <= last_wr_d;
      granted_q  <= granted_d;
      id_q       <= id_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      size_err_q <= size_err_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
    end
  end

  // The state register sits in Idle during reset, so the grant decode alone would follow
  // ar_valid/aw_valid; gate it so the readies are low for the whole reset.
  assign ar_ready  = ar_grant & reset_n;
  assign aw_ready  = aw_grant & reset_n;

  assign w_ready   = (state_q == StWrData);
  assign req_valid = (state_q == StRdReq) || (state_q == StWrReq);
  assign req_wr    = (state_q == StWrReq);
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;

  assign r_valid   = (state_q == StRdData);
  assign r_data    = rdata_q;
  assign r_id      = id_q;
  assign r_last    = r_valid && final_beat;
  assign r_resp    = (r_valid && err_q) ? RESP_SLVERR : RESP_OKAY;

  assign b_valid   = (state_q == StWrResp);
  assign b_id      = id_q;
  assign b_resp    = (b_valid && err_q) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_nasti_mmio_bridge.sv
// Self-checking bench for nasti_mmio_bridge: directed scenarios followed by random bursts,
// checked against a word-array register model and per-burst expectations.
module tb_nasti_mmio_bridge;

  localparam int AW = 12;
  localparam int IW = 12;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ar_valid = 0, aw_valid = 0, w_valid = 0, w_last = 0, b_ready = 0, r_ready = 0;
  logic [31:0] ar_addr = 0, aw_addr = 0, w_data = 0;
  logic [IW-1:0] ar_id = 0, aw_id = 0;
  logic [7:0] ar_len = 0, aw_len = 0;
  logic [2:0] ar_size = 0, aw_size = 0;
  logic req_ready = 0, resp_valid = 0, resp_err = 0;
  logic [31:0] resp_rdata = 0;
  logic ar_ready, aw_ready, w_ready, b_valid, r_valid, r_last, req_valid, req_wr;
  logic [IW-1:0] b_id, r_id;
  logic [1:0] b_resp, r_resp;
  logic [31:0] r_data, req_wdata;
  logic [AW-1:0] req_addr;

  always #5 clk = ~clk;

  nasti_mmio_bridge #(.ADDR_W(AW), .ID_W(IW)) dut (
    .clk(clk), .reset_n(reset_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_len(aw_len), .aw_size(aw_size),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id), .r_last(r_last),
    .r_resp(r_resp),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  typedef struct { bit wr; int addr; logic [31:0] data; } req_t;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int grant_cyc = 0;
  int err_addr = -1;
  bit fixed_ready = 0, stray_en = 0, hold_resp = 0, pend = 0;
  logic [31:0] pend_data;
  logic pend_err;
  logic [31:0] mem [NW];
  logic [31:0] wdat [256];
  req_t req_log[$];

  initial forever @(posedge clk) cyc++;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  // Register target: logs every request, answers one cycle after acceptance and
  // occasionally pulses a stray erroring resp_valid while the bridge is not waiting.
  initial begin
    forever begin
      @(negedge clk);
      resp_valid = 0; resp_rdata = 0; resp_err = 0;
      if (!reset_n) begin
        pend = 0; req_ready = 0;
        continue;
      end
      if (pend && !hold_resp) begin
        resp_valid = 1; resp_rdata = pend_data; resp_err = pend_err; pend = 0;
      end else if (!pend && stray_en && ($urandom % 4 == 0) &&
                   (req_valid || r_valid || w_ready || b_valid)) begin
        resp_valid = 1; resp_rdata = $urandom; resp_err = 1;
      end
      req_ready = fixed_ready ? 1'b1 : 1'($urandom % 2);
      if (req_valid && req_ready) begin
        req_log.push_back('{wr: req_wr, addr: int'(req_addr), data: req_wdata});
        if (req_wr) mem[req_addr] = req_wdata;
        pend_data = req_wr ? 32'h0 : mem[req_addr];
        pend_err  = (int'(req_addr) == err_addr);
        pend = 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, 32'({ar_ready, aw_ready, w_ready, b_valid, r_valid, r_last,
                           req_valid, req_wr, b_resp, r_resp}), 32'h0);
    chk({tag, "_rdata"}, r_data, 32'h0);
    chk({tag, "_ids"}, 32'({r_id, b_id}), 32'h0);
    chk({tag, "_req_addr"}, 32'(req_addr), 32'h0);
    chk({tag, "_req_wdata"}, req_wdata, 32'h0);
  endtask

  function automatic logic [31:0] mkaddr(input int word);
    return ($urandom & 32'hFFFF_C000) | (32'(word % NW) << 2) | ($urandom & 32'h3);
  endfunction

  task automatic set_ar(input logic [31:0] a, input logic [IW-1:0] id, input int len,
                        input logic [2:0] size);
    ar_addr = a; ar_id = id; ar_len = 8'(len); ar_size = size; ar_valid = 1;
  endtask

  task automatic set_aw(input logic [31:0] a, input logic [IW-1:0] id, input int len,
                        input logic [2:0] size);
    aw_addr = a; aw_id = id; aw_len = 8'(len); aw_size = size; aw_valid = 1;
  endtask

  task automatic hs_ar();
    int t = 0;
    #1;
    while (!ar_ready && t < 100) begin @(negedge clk); #1; t++; end
    chk("ar_grant", 32'(ar_ready), 32'h1);
    grant_cyc = cyc;
    @(posedge clk); @(negedge clk);
    chk("ar_ready_pulse", 32'(ar_ready), 32'h0);
    ar_valid = 0;
  endtask

  task automatic hs_aw();
    int t = 0;
    #1;
    while (!aw_ready && t < 100) begin @(negedge clk); #1; t++; end
    chk("aw_grant", 32'(aw_ready), 32'h1);
    @(posedge clk); @(negedge clk);
    chk("aw_ready_pulse", 32'(aw_ready), 32'h0);
    aw_valid = 0;
  endtask

  task automatic rd_beats(input logic [IW-1:0] id, input int word, input int len,
                          input bit size_ok, output int lat);
    int t, w, nexp;
    logic [31:0] ed;
    logic [1:0] er;
    lat = -1;
    for (int i = 0; i <= len; i++) begin
      t = 0;
      while (!r_valid && t < 200) begin @(negedge clk); t++; end
      chk("r_valid_wait", 32'(r_valid), 32'h1);
      if (i == 0) lat = cyc - grant_cyc;
      if ($urandom % 3 == 0) begin
        repeat (1 + $urandom % 2) @(negedge clk);
        chk("r_hold", 32'(r_valid), 32'h1);
      end
      w  = (word + i) % NW;
      ed = size_ok ? mem[w] : 32'h0;
      er = (!size_ok || w == err_addr) ? 2'b10 : 2'b00;
      chk("r_data", r_data, ed);
      chk("r_resp", 32'(r_resp), 32'(er));
      chk("r_last", 32'(r_last), 32'(i == len));
      chk("r_id", 32'(r_id), 32'(id));
      r_ready = 1; @(posedge clk); @(negedge clk); r_ready = 0;
    end
    chk("r_after", 32'(r_valid), 32'h0);
    nexp = size_ok ? len + 1 : 0;
    chk("rd_req_count", 32'(req_log.size()), 32'(nexp));
    for (int i = 0; i < req_log.size() && i < nexp; i++) begin
      chk("rd_req_wr", 32'(req_log[i].wr), 32'h0);
      chk("rd_req_addr", 32'(req_log[i].addr), 32'((word + i) % NW));
    end
    req_log.delete();
  endtask

  task automatic wr_beats(input logic [IW-1:0] id, input int word, input int len,
                          input bit size_ok, input int bad_idx, input bit seq);
    int t, w, nexp;
    bit exp_err;
    req_log.delete();
    exp_err = !size_ok;
    for (int i = 0; i <= len; i++) begin
      w = (word + i) % NW;
      wdat[i] = seq ? 32'(i + 1) : $urandom;
      w_data = wdat[i];
      w_last = (i == len) ^ (i == bad_idx);
      if (i == bad_idx) exp_err = 1;
      if (size_ok && w == err_addr) exp_err = 1;
      w_valid = 1;
      t = 0;
      #1;
      while (!w_ready && t < 200) begin @(negedge clk); #1; t++; end
      chk("w_accept", 32'(w_ready), 32'h1);
      @(posedge clk); @(negedge clk);
      w_valid = 0; w_last = 0;
    end
    t = 0;
    while (!b_valid && t < 200) begin @(negedge clk); t++; end
    chk("b_valid_wait", 32'(b_valid), 32'h1);
    if ($urandom % 2 == 1) begin
      @(negedge clk);
      chk("b_hold", 32'(b_valid), 32'h1);
    end
    chk("b_resp", 32'(b_resp), exp_err ? 32'h2 : 32'h0);
    chk("b_id", 32'(b_id), 32'(id));
    b_ready = 1; @(posedge clk); @(negedge clk); b_ready = 0;
    chk("b_after", 32'(b_valid), 32'h0);
    nexp = size_ok ? len + 1 : 0;
    chk("wr_req_count", 32'(req_log.size()), 32'(nexp));
    for (int i = 0; i < req_log.size() && i < nexp; i++) begin
      chk("wr_req_wr", 32'(req_log[i].wr), 32'h1);
      chk("wr_req_addr", 32'(req_log[i].addr), 32'((word + i) % NW));
      chk("wr_req_data", req_log[i].data, wdat[i]);
    end
    req_log.delete();
  endtask

  int lat, t, seen, word, len, bidx;
  bit wr, ok;
  logic [2:0] size;
  logic [IW-1:0] id;

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = $urandom;

    // Reset with both address channels already requesting: everything must stay low.
    set_ar(mkaddr(20), 12'd3, 1, 3'd2);
    set_aw(mkaddr(30), 12'd4, 0, 3'd2);
    #12;
    chk_quiet("reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    stray_en = 1;

    // First simultaneous pair after reset: read wins.
    #1;
    chk("tie1_ar_ready", 32'(ar_ready), 32'h1);
    chk("tie1_aw_ready", 32'(aw_ready), 32'h0);
    hs_ar(); rd_beats(12'd3, 20, 1, 1, lat);
    hs_aw(); wr_beats(12'd4, 30, 0, 1, -1, 0);

    // Single read, fixed-latency target.
    fixed_ready = 1; stray_en = 0;
    mem[16] = 32'hDEAD_BEEF;
    set_ar(32'h40, 12'd5, 0, 3'd2);
    hs_ar(); rd_beats(12'd5, 16, 0, 1, lat);
    chk("rd_latency", 32'(lat), 32'd3);
    fixed_ready = 0; stray_en = 1;

    // Second simultaneous pair: write wins (last grant was a read).
    set_ar(mkaddr(200), 12'd11, 0, 3'd2);
    set_aw(mkaddr(300), 12'd12, 1, 3'd2);
    #1;
    chk("tie2_ar_ready", 32'(ar_ready), 32'h0);
    chk("tie2_aw_ready", 32'(aw_ready), 32'h1);
    hs_aw(); wr_beats(12'd12, 300, 1, 1, -1, 0);
    hs_ar(); rd_beats(12'd11, 200, 0, 1, lat);

    // Write burst, data 1..4 at word 0x40.
    set_aw(32'h100, 12'd9, 3, 3'd2);
    hs_aw(); wr_beats(12'd9, 'h40, 3, 1, -1, 1);

    // Unsupported write size: beats consumed, no requests, SLVERR.
    set_aw(mkaddr(50), 12'd13, 1, 3'd1);
    hs_aw(); wr_beats(12'd13, 50, 1, 0, -1, 0);

    // Read burst with a register error on the middle beat.
    err_addr = 61;
    set_ar(mkaddr(60), 12'd14, 2, 3'd2);
    hs_ar(); rd_beats(12'd14, 60, 2, 1, lat);
    err_addr = -1;

    // Unsupported read size, address wrap, w_last missing / early, longest burst.
    set_ar(mkaddr(7), 12'd16, 2, 3'd0);
    hs_ar(); rd_beats(12'd16, 7, 2, 0, lat);
    set_ar(mkaddr(NW - 2), 12'd15, 3, 3'd2);
    hs_ar(); rd_beats(12'd15, NW - 2, 3, 1, lat);
    set_aw(mkaddr(80), 12'd17, 2, 3'd2);
    hs_aw(); wr_beats(12'd17, 80, 2, 1, 2, 0);
    set_aw(mkaddr(90), 12'd19, 2, 3'd2);
    hs_aw(); wr_beats(12'd19, 90, 2, 1, 0, 0);
    set_aw(mkaddr(NW - 10), 12'd18, 255, 3'd2);
    hs_aw(); wr_beats(12'd18, NW - 10, 255, 1, -1, 0);

    // Random bursts.
    for (int k = 0; k < 30; k++) begin
      wr   = 1'($urandom % 2);
      word = ($urandom % 4 == 0) ? NW - 1 - int'($urandom % 3) : int'($urandom % NW);
      len  = int'($urandom % 6);
      ok   = ($urandom % 6) != 0;
      size = ok ? 3'd2 : (($urandom % 2 == 1) ? 3'd1 : 3'd3);
      bidx = (wr && $urandom % 5 == 0) ? int'($urandom % (len + 1)) : -1;
      err_addr = ($urandom % 4 == 0) ? (word + int'($urandom % (len + 1))) % NW : -1;
      id   = IW'($urandom);
      if (wr) begin
        set_aw(mkaddr(word), id, len, size);
        hs_aw(); wr_beats(id, word, len, ok, bidx, 0);
      end else begin
        set_ar(mkaddr(word), id, len, size);
        hs_ar(); rd_beats(id, word, len, ok, lat);
      end
    end
    err_addr = -1;

    // Reset while the bridge waits for a write response.
    hold_resp = 1;
    req_log.delete();
    set_aw(mkaddr(100), 12'd7, 1, 3'd2);
    hs_aw();
    w_data = 32'hA5A5_0001; w_last = 0; w_valid = 1;
    t = 0;
    #1;
    while (!w_ready && t < 100) begin @(negedge clk); #1; t++; end
    @(posedge clk); @(negedge clk);
    w_valid = 0;
    t = 0;
    while (req_log.size() == 0 && t < 100) begin @(negedge clk); t++; end
    chk("abort_req_issued", 32'(req_log.size()), 32'h1);
    repeat (2) @(negedge clk);
    #2;
    set_ar(mkaddr(5), 12'd21, 0, 3'd2);
    set_aw(mkaddr(6), 12'd22, 0, 3'd2);
    reset_n = 0;
    #1;
    chk_quiet("abort");
    @(negedge clk);
    ar_valid = 0; aw_valid = 0; hold_resp = 0;
    @(negedge clk);
    reset_n = 1;
    seen = 0;
    repeat (6) begin @(negedge clk); seen += int'(b_valid); end
    chk("abort_no_b", 32'(seen), 32'h0);
    req_log.delete();
    set_ar(mkaddr(5), 12'd23, 1, 3'd2);
    hs_ar(); rd_beats(12'd23, 5, 1, 1, lat);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
